// File: rtl/keypad_scan_module.sv
// keypad_scan_module
//   Scans a 4x4 matrix keypad one column at a time. It produces a debounced key
//   code, a one-cycle press strobe and a held level.
//
//   state | meaning
//   IDLE  | no key accepted; waiting for a stable single-key scan
//   HELD  | key accepted; waiting for a stable all-released scan
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   row_n     keypad rows, active-low, asynchronous to clk
//   col_n     column drive, active-low one-hot
//   key_code  {row_idx, col_idx} of the last accepted key
//   key_valid one-cycle strobe on a newly accepted press
//   key_down  high while the accepted key is held
module keypad_scan_module #(
  parameter int unsigned SCAN_BITS      = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  localparam logic [1:0]           RES_NONE   = 2'd0;
  localparam logic [1:0]           RES_SINGLE = 2'd1;
  localparam logic [1:0]           RES_MULTI  = 2'd2;
  localparam logic [3:0]           STABLE_MAX = 4'(DEBOUNCE_SCANS);
  localparam logic [SCAN_BITS-1:0] DWELL_ONE  = SCAN_BITS'(1);

  logic [3:0]           row_meta, row_sync;
  logic [SCAN_BITS-1:0] dwell;
  logic [1:0]           col_idx;
  logic                 sample, scan_end;
  logic [1:0]           acc_cnt;
  logic [3:0]           acc_code;
  logic [3:0]           row_hit;
  logic [2:0]           hit_sum, tot_sum;
  logic [1:0]           col_hits, first_row, scan_cnt;
  logic [3:0]           scan_code;
  logic [5:0]           result, prev_result;
  logic [3:0]           stable_cnt, stable_cnt_nxt;
  logic                 stable;
  state_t               state, state_nxt;
  logic                 valid_nxt, load_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  assign sample   = &dwell;
  assign scan_end = sample && (col_idx == 2'd3);
  assign col_n    = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      col_idx <= 2'd0;
    end else begin
      dwell <= dwell + DWELL_ONE;
      if (sample) col_idx <= col_idx + 2'd1;
    end
  end

  // Fold the current column into the running scan tally. The count saturates
  // at 2 because only none/one/many matters. The code is captured only for
  // the first pressed switch, so columns are visited in ascending order and
  // rows are priority-encoded low-first.
  always_comb begin
    row_hit   = ~row_sync;
    hit_sum   = {2'b00, row_hit[0]} + {2'b00, row_hit[1]} +
                {2'b00, row_hit[2]} + {2'b00, row_hit[3]};
    col_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    tot_sum   = {1'b0, acc_cnt} + {1'b0, col_hits};
    scan_cnt  = (tot_sum >= 3'd2) ? 2'd2 : tot_sum[1:0];
    first_row = row_hit[0] ? 2'd0 : row_hit[1] ? 2'd1 : row_hit[2] ? 2'd2 : 2'd3;
    scan_code = ((acc_cnt == 2'd0) && (row_hit != 4'd0)) ? {first_row, col_idx} : acc_code;
    case (scan_cnt)
      2'd0:    result = {RES_NONE, 4'd0};
      2'd1:    result = {RES_SINGLE, scan_code};
      default: result = {RES_MULTI, 4'd0};
    endcase
    if (result == prev_result)
      stable_cnt_nxt = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 4'd1;
    else
      stable_cnt_nxt = 4'd1;
    stable = scan_end && (stable_cnt_nxt == STABLE_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt     <= 2'd0;
      acc_code    <= 4'd0;
      prev_result <= {RES_NONE, 4'd0};
      stable_cnt  <= 4'd0;
    end else if (sample) begin
      if (scan_end) begin
        acc_cnt     <= 2'd0;
        acc_code    <= 4'd0;
        prev_result <= result;
        stable_cnt  <= stable_cnt_nxt;
      end else begin
        acc_cnt  <= scan_cnt;
        acc_code <= scan_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    load_code = 1'b0;
    case (state)
      IDLE: if (stable && (result[5:4] == RES_SINGLE)) begin
        state_nxt = HELD;
        valid_nxt = 1'b1;
        load_code = 1'b1;
      end
      HELD: if (stable && (result[5:4] == RES_NONE)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_valid <= valid_nxt;
      if (load_code) key_code <= result[3:0];
    end
  end

  assign key_down = (state == HELD);

endmodule

// File: tb/tb_keypad_scan_module.sv
// Testbench for keypad_scan_module (SCAN_BITS=2, DEBOUNCE_SCANS=3).
// A keypad model drives row_n from the pressed-key mask and the column drive.
// Each scan pushes its expected end-of-scan outcome to a queue. The outcome is
// popped and compared after the scan-end edge.
module tb_keypad_scan_module;
  localparam int SCAN_BITS = 2;
  localparam int DEB       = 3;
  localparam int SCAN_LEN  = 16;

  typedef struct packed {
    logic       valid;
    logic       down;
    logic [3:0] code;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n, col_n, key_code;
  logic        key_valid, key_down;
  logic [15:0] pressed = '0;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  logic [5:0] hist[$];
  logic       m_held = 1'b0;
  logic [3:0] m_code = 4'd0;

  always #5 clk = ~clk;

  keypad_scan_module #(.SCAN_BITS(SCAN_BITS), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  // Key index r*4+c connects row r to column c.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result encoding: {kind, code} where kind 0=none, 1=single, 2=multi.
  function automatic logic [5:0] scan_result(input logic [15:0] keys);
    int n = 0;
    logic [3:0] code = 4'd0;
    for (int i = 0; i < 16; i++)
      if (keys[i]) begin
        n++;
        code = 4'(i);
      end
    if (n == 0) return 6'h00;
    if (n == 1) return {2'd1, code};
    return {2'd2, 4'd0};
  endfunction

  task automatic push_expect(input logic [15:0] keys);
    exp_t e;
    logic [5:0] res;
    logic stable;
    res = scan_result(keys);
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB);
    foreach (hist[k]) if (hist[k] != res) stable = 1'b0;
    e.valid = 1'b0;
    if (!m_held && stable && res[5:4] == 2'd1) begin
      m_held  = 1'b1;
      m_code  = res[3:0];
      e.valid = 1'b1;
    end else if (m_held && stable && res[5:4] == 2'd0) begin
      m_held = 1'b0;
    end
    e.down = m_held;
    e.code = m_code;
    sb_q.push_back(e);
  endtask

  // Runs one full scan starting right after a scan boundary.
  task automatic do_scan(input logic [15:0] keys);
    int extra;
    exp_t e;
    logic [3:0] exp_col;
    pressed = keys;
    push_expect(keys);
    extra = 0;
    check("col_n_pos0", col_n, 4'b1110);
    for (int j = 1; j < SCAN_LEN; j++) begin
      @(posedge clk); #1;
      exp_col = ~(4'b0001 << (j / 4));
      check("col_n", col_n, exp_col);
      if (key_valid) extra++;
    end
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("key_valid", key_valid, e.valid);
      check("key_down", key_down, e.down);
      check("key_code", key_code, e.code);
    end
    check("stray_strobe", extra, 0);
  endtask

  task automatic reset_at(input int pos);
    for (int j = 0; j < pos; j++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_down", key_down, 0);
    check("rst_key_code", key_code, 0);
    sb_q.delete();
    hist.delete();
    m_held = 1'b0;
    m_code = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K3  = 16'h0008;
  localparam logic [15:0] K5  = 16'h0020;
  localparam logic [15:0] K10 = 16'h0400;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("init_col_n", col_n, 4'b1110);
    check("init_key_valid", key_valid, 0);
    check("init_key_down", key_down, 0);
    check("init_key_code", key_code, 0);
    rst_n = 1'b1;

    repeat (3) do_scan('0);
    reset_at(6);
    repeat (3) do_scan('0);

    repeat (5) do_scan(K9);
    repeat (4) do_scan('0);

    for (int i = 0; i < 5; i++) do_scan((i % 2 == 0) ? K9 : 16'h0000);
    repeat (4) do_scan(K9);
    repeat (4) do_scan('0);

    repeat (4) do_scan(K3);
    repeat (4) do_scan('0);

    repeat (4) do_scan(K5 | K10);
    repeat (4) do_scan('0);

    repeat (3) do_scan(K5);
    repeat (3) do_scan(K5 | K10);
    repeat (3) do_scan(K10);
    repeat (4) do_scan('0);

    repeat (4) do_scan(K5);
    reset_at(7);
    repeat (4) do_scan(K5);
    repeat (4) do_scan('0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
